coefficient_streamer: RTL and testbench

Read-side counterpart of `coefficient_loader`. It holds a bank of NUM_TAPS filter coefficients written over the loader's write port. On request, it streams them in tap order to the FIR MAC datapath over a valid/ready handshake. It sits between `coefficient_loader` (write side) and the MAC (consumer side).

---
 rtl/coefficient_streamer.sv | 132 +++++++++++++
 tb/tb_coefficient_streamer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coefficient_streamer.sv
// Coefficient bank written by coefficient_loader and streamed in tap order to the FIR MAC.
// Define COEFF_WRAP_EN to let a start at the final handshake wrap straight into the next pass.
module coefficient_streamer #(
    parameter int NUM_TAPS = 4,
    parameter int COEFF_W  = 16,
    localparam int ADDR_W  = $clog2(NUM_TAPS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [COEFF_W-1:0] load_data,
    input  logic               load_done,
    input  logic               start,
    output logic               coeff_valid,
    input  logic               coeff_ready,
    output logic [COEFF_W-1:0] coeff_data,
    output logic [ADDR_W-1:0]  coeff_idx,
    output logic               coeff_last,
    output logic               busy,
    output logic               loaded,
    output logic               err
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_TAPS - 1);

    state_t             state;
    logic [COEFF_W-1:0] bank [NUM_TAPS];

    logic addr_ok;
    logic write_ok;
    logic handshake;
    logic at_last;
    logic wrap_go;
    logic start_ok;
    logic err_event;

    assign addr_ok   = 32'(load_addr) < 32'(NUM_TAPS);
    assign write_ok  = load_en & (state == IDLE) & addr_ok;
    assign handshake = coeff_valid & coeff_ready;
    assign at_last   = coeff_idx == LAST_IDX;
    assign start_ok  = (state == IDLE) & start & loaded & ~load_en;

    // A start that loses to a write, or arrives before the bank is complete, is a protocol error.
    assign err_event = (load_en & ~write_ok)
                     | ((state == IDLE) & start & (load_en | ~loaded));

`ifdef COEFF_WRAP_EN
    assign wrap_go = start;
`else
    assign wrap_go = 1'b0;
`endif

    assign coeff_data = bank[coeff_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                bank[i] <= '0;
            end
        end else if (write_ok) begin
            bank[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            coeff_idx   <= '0;
            coeff_valid <= 1'b0;
            coeff_last  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state       <= STREAM;
                        coeff_idx   <= '0;
                        coeff_valid <= 1'b1;
                        coeff_last  <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                STREAM: begin
                    if (handshake) begin
                        if (!at_last) begin
                            coeff_idx  <= coeff_idx + ADDR_W'(1);
                            coeff_last <= (coeff_idx + ADDR_W'(1)) == LAST_IDX;
                        end else if (wrap_go) begin
                            coeff_idx  <= '0;
                            coeff_last <= 1'b0;
                        end else begin
                            state       <= IDLE;
                            coeff_idx   <= '0;
                            coeff_valid <= 1'b0;
                            coeff_last  <= 1'b0;
                            busy        <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    coeff_idx   <= '0;
                    coeff_valid <= 1'b0;
                    coeff_last  <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    // load_done wins over a same-cycle write so the bank ends up marked complete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loaded <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (load_done) begin
                loaded <= 1'b1;
            end else if (write_ok) begin
                loaded <= 1'b0;
            end
            err <= (err & ~load_done) | err_event;
        end
    end

endmodule

// File: tb/tb_coefficient_streamer.sv
// Directed bench for coefficient_streamer: cycle model of the bank/stream rules plus literal spot checks.
module tb_coefficient_streamer;

    localparam int N = 4;
    localparam int W = 16;
`ifdef COEFF_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_en = 1'b0;
    logic [1:0]   load_addr = '0;
    logic [W-1:0] load_data = '0;
    logic         load_done = 1'b0;
    logic         start = 1'b0;
    logic         coeff_ready = 1'b0;
    logic         coeff_valid;
    logic [W-1:0] coeff_data;
    logic [1:0]   coeff_idx;
    logic         coeff_last;
    logic         busy;
    logic         loaded;
    logic         err;

    logic         load_en6 = 1'b0;
    logic [2:0]   load_addr6 = '0;
    logic         load_done6 = 1'b0;
    logic         coeff_valid6;
    logic [W-1:0] coeff_data6;
    logic [2:0]   coeff_idx6;
    logic         coeff_last6;
    logic         busy6;
    logic         loaded6;
    logic         err6;

    always #5 clk = ~clk;

    coefficient_streamer #(.NUM_TAPS(N), .COEFF_W(W)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .load_done(load_done), .start(start),
        .coeff_valid(coeff_valid), .coeff_ready(coeff_ready), .coeff_data(coeff_data),
        .coeff_idx(coeff_idx), .coeff_last(coeff_last), .busy(busy),
        .loaded(loaded), .err(err)
    );

    // Six-tap instance: the only way to present an out-of-range address on the write port.
    coefficient_streamer #(.NUM_TAPS(6), .COEFF_W(W)) dut6 (
        .clk(clk), .rst(rst), .load_en(load_en6), .load_addr(load_addr6),
        .load_data(16'h1234), .load_done(load_done6), .start(1'b0),
        .coeff_valid(coeff_valid6), .coeff_ready(1'b1), .coeff_data(coeff_data6),
        .coeff_idx(coeff_idx6), .coeff_last(coeff_last6), .busy(busy6),
        .loaded(loaded6), .err(err6)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bank contents, pass in progress, current tap, flags.
    logic [W-1:0] m_bank [N];
    bit           m_stream;
    bit           m_loaded;
    bit           m_err;
    int           m_idx;

    initial begin
        bit ev;
        bit wr;
        for (int i = 0; i < N; i++) m_bank[i] = '0;
        m_stream = 0; m_loaded = 0; m_err = 0; m_idx = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int i = 0; i < N; i++) m_bank[i] = '0;
                m_stream = 0; m_loaded = 0; m_err = 0; m_idx = 0;
            end else begin
                ev = 0;
                wr = 0;
                if (load_en) begin
                    if (m_stream || int'(load_addr) >= N) ev = 1;
                    else wr = 1;
                end
                if (m_stream) begin
                    if (coeff_ready) begin
                        if (m_idx < N - 1) m_idx = m_idx + 1;
                        else if (WRAP && start) m_idx = 0;
                        else begin
                            m_stream = 0;
                            m_idx = 0;
                        end
                    end
                end else if (start) begin
                    if (load_en || !m_loaded) ev = 1;
                    else begin
                        m_stream = 1;
                        m_idx = 0;
                    end
                end
                if (wr) m_bank[load_addr] = load_data;
                if (load_done) m_loaded = 1;
                else if (wr) m_loaded = 0;
                m_err = (m_err && !load_done) || ev;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_valid", 32'(coeff_valid), 32'(m_stream));
            chk("m_busy", 32'(busy), 32'(m_stream));
            chk("m_loaded", 32'(loaded), 32'(m_loaded));
            chk("m_err", 32'(err), 32'(m_err));
            if (m_stream) begin
                chk("m_idx", 32'(coeff_idx), 32'(m_idx));
                chk("m_data", 32'(coeff_data), 32'(m_bank[m_idx]));
                chk("m_last", 32'(coeff_last), 32'(m_idx == N - 1));
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic write(input int a, input logic [W-1:0] d);
        load_en = 1'b1;
        load_addr = a[1:0];
        load_data = d;
        step();
        load_en = 1'b0;
    endtask

    task automatic pulse_done();
        load_done = 1'b1;
        step();
        load_done = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    logic [W-1:0] exp1 [N];
    logic [W-1:0] exp2 [N];
    bit           wv [10];
    int           wi [10];

    initial begin
        exp1 = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        exp2 = '{16'h0055, 16'h0022, 16'h0077, 16'h0099};
        if (WRAP) begin
            wv = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
            wi = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 0};
        end else begin
            wv = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
            wi = '{0, 1, 2, 3, 0, 0, 1, 2, 3, 0};
        end

        step();
        step();
        rst = 1'b0;
        chk("rst_valid", 32'(coeff_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_loaded", 32'(loaded), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_data", 32'(coeff_data), 0);

        // load then stream
        for (int i = 0; i < N; i++) write(i, exp1[i]);
        pulse_done();
        chk("loaded_after_done", 32'(loaded), 1);
        coeff_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < N; i++) begin
            chk("pass1_data", 32'(coeff_data), 32'(exp1[i]));
            chk("pass1_idx", 32'(coeff_idx), 32'(i));
            chk("pass1_last", 32'(coeff_last), 32'(i == N - 1));
            step();
        end
        chk("pass1_busy_end", 32'(busy), 0);
        chk("pass1_valid_end", 32'(coeff_valid), 0);

        // backpressure at tap 2
        pulse_start();
        step();
        step();
        coeff_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_data", 32'(coeff_data), 32'h0033);
            chk("bp_idx", 32'(coeff_idx), 2);
        end
        coeff_ready = 1'b1;
        step();
        chk("bp_resume_idx", 32'(coeff_idx), 3);
        step();
        chk("bp_busy_end", 32'(busy), 0);

        // protocol errors
        write(0, 16'h0055);
        chk("write_clears_loaded", 32'(loaded), 0);
        pulse_start();
        chk("start_unloaded_err", 32'(err), 1);
        chk("start_unloaded_valid", 32'(coeff_valid), 0);
        pulse_done();
        chk("done_clears_err", 32'(err), 0);
        pulse_start();
        load_en = 1'b1; load_addr = 2'd1; load_data = 16'hBEEF;
        step();
        load_en = 1'b0;
        chk("stream_write_err", 32'(err), 1);
        step();
        step();
        step();
        chk("stream_write_busy_end", 32'(busy), 0);

        // simultaneous events
        load_en = 1'b1; load_addr = 2'd3; load_data = 16'h0099; load_done = 1'b1;
        step();
        load_en = 1'b0; load_done = 1'b0;
        chk("wr_done_loaded", 32'(loaded), 1);
        chk("wr_done_err", 32'(err), 0);
        start = 1'b1; load_en = 1'b1; load_addr = 2'd2; load_data = 16'h0077;
        step();
        start = 1'b0; load_en = 1'b0;
        chk("start_wr_valid", 32'(coeff_valid), 0);
        chk("start_wr_err", 32'(err), 1);
        chk("start_wr_loaded", 32'(loaded), 0);
        pulse_done();
        pulse_start();
        for (int i = 0; i < N; i++) begin
            chk("pass2_data", 32'(coeff_data), 32'(exp2[i]));
            step();
        end
        chk("pass2_busy_end", 32'(busy), 0);

        // out-of-range address on the six-tap instance
        load_en6 = 1'b1; load_addr6 = 3'd6;
        step();
        load_en6 = 1'b0;
        chk("oor6_err", 32'(err6), 1);
        chk("oor6_loaded", 32'(loaded6), 0);
        load_done6 = 1'b1;
        step();
        load_done6 = 1'b0;
        chk("oor6_done_err", 32'(err6), 0);
        chk("oor6_done_loaded", 32'(loaded6), 1);
        load_en6 = 1'b1; load_addr6 = 3'd5;
        step();
        chk("inrange6_err", 32'(err6), 0);
        chk("inrange6_loaded", 32'(loaded6), 0);
        load_addr6 = 3'd7;
        step();
        load_en6 = 1'b0;
        chk("oor6_7_err", 32'(err6), 1);

        // start held across the pass boundary
        start = 1'b1;
        for (int n = 0; n < 10; n++) begin
            step();
            chk("hold_valid", 32'(coeff_valid), 32'(wv[n]));
            if (wv[n]) chk("hold_idx", 32'(coeff_idx), 32'(wi[n]));
            if (n == 7) start = 1'b0;
        end
        step();

        // reset in the middle of a pass
        pulse_start();
        step();
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(coeff_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_loaded", 32'(loaded), 0);
        chk("midrst_err", 32'(err), 0);
        chk("midrst_idx", 32'(coeff_idx), 0);
        chk("midrst_data", 32'(coeff_data), 0);
        step();
        rst = 1'b0;
        pulse_done();
        pulse_start();
        for (int i = 0; i < N; i++) begin
            chk("zero_bank_data", 32'(coeff_data), 0);
            step();
        end
        chk("zero_pass_busy_end", 32'(busy), 0);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
